// File: rtl/frame_tx.sv
// Serial frame transmitter: marker 0,0,1 then payload MSB-first
// and optional parity bit on the registered line x, idle-high.
module frame_tx #(
    parameter int WIDTH     = 8,
    parameter bit PARITY_EN = 1'b1,
    parameter bit PAR_ODD   = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic             x,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MK0  = 3'd1,
        MK1  = 3'd2,
        MK2  = 3'd3,
        DATA = 3'd4,
        PAR  = 3'd5
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_par;
    logic             r_x;
    logic             r_busy;
    logic             r_done;
    logic             w_msb;
    logic             w_last;

    assign w_msb  = r_shreg[WIDTH-1];
    assign w_last = (r_cnt == CW'(WIDTH - 1));

    // Frame sequencer; outputs are loaded with the value of the next cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_shreg <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_x     <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_shreg <= din;
                        r_par   <= PAR_ODD;
                        r_cnt   <= '0;
                        r_x     <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= MK0;
                    end
                end
                MK0: begin
                    r_x     <= 1'b0;
                    r_state <= MK1;
                end
                MK1: begin
                    r_x     <= 1'b1;
                    r_state <= MK2;
                end
                MK2: begin
                    // First payload bit goes out; parity tracks it
                    r_x     <= w_msb;
                    r_par   <= r_par ^ w_msb;
                    r_shreg <= r_shreg << 1;
                    r_cnt   <= '0;
                    r_state <= DATA;
                end
                DATA: begin
                    if (w_last) begin
                        if (PARITY_EN) begin
                            r_x     <= r_par;
                            r_state <= PAR;
                        end else begin
                            r_x     <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_x     <= w_msb;
                        r_par   <= r_par ^ w_msb;
                        r_shreg <= r_shreg << 1;
                        r_cnt   <= r_cnt + 1'b1;
                    end
                end
                PAR: begin
                    r_x     <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: begin
                    r_x     <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign x    = r_x;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_frame_tx.sv
// Directed bench for frame_tx: even/odd parity instances
// and a 4-bit no-parity instance sharing the same stimulus.
module tb_frame_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] din;
    logic       x_e, busy_e, done_e;
    logic       x_o, busy_o, done_o;
    logic       x_n, busy_n, done_n;

    int vecs;
    int errs;

    frame_tx #(.WIDTH(8), .PARITY_EN(1'b1), .PAR_ODD(1'b0)) u_e (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .x(x_e), .busy(busy_e), .done(done_e)
    );

    frame_tx #(.WIDTH(8), .PARITY_EN(1'b1), .PAR_ODD(1'b1)) u_o (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .x(x_o), .busy(busy_o), .done(done_o)
    );

    frame_tx #(.WIDTH(4), .PARITY_EN(1'b0), .PAR_ODD(1'b0)) u_n (
        .clk(clk), .reset(reset), .start(start), .din(din[3:0]),
        .x(x_n), .busy(busy_n), .done(done_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One frame: exp/poke indexed MSB = first busy cycle
    task automatic send(input string tag, input logic [7:0] d,
                        input bit odd, input logic [11:0] exp,
                        input logic [11:0] poke, input bit np);
        logic [6:0] expn;
        logic xs, bs, ds;
        expn = 7'b0010101;
        din = d;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            xs = odd ? x_o : x_e;
            bs = odd ? busy_o : busy_e;
            ds = odd ? done_o : done_e;
            chk({tag, "_x"}, xs, exp[11-i]);
            chk({tag, "_bd"}, {bs, ds}, 2'b10);
            if (np) begin
                if (i < 7) begin
                    chk({tag, "_nx"}, x_n, expn[6-i]);
                    chk({tag, "_nbd"}, {busy_n, done_n}, 2'b10);
                end else if (i == 7) begin
                    chk({tag, "_ngap"}, {x_n, busy_n, done_n}, 3'b101);
                end
            end
            start = poke[11-i];
            tick();
            start = 1'b0;
        end
        xs = odd ? x_o : x_e;
        bs = odd ? busy_o : busy_e;
        ds = odd ? done_o : done_e;
        chk({tag, "_gap"}, {xs, bs, ds}, 3'b101);
        tick();
        xs = odd ? x_o : x_e;
        bs = odd ? busy_o : busy_e;
        ds = odd ? done_o : done_e;
        chk({tag, "_idle"}, {xs, bs, ds}, 3'b100);
    endtask

    initial begin
        vecs  = 0;
        errs  = 0;
        reset = 1'b0;
        start = 1'b0;
        din   = 8'h00;

        // Reset held with start toggling
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            din   = 8'hA5;
            tick();
            chk("rst_e", {x_e, busy_e, done_e}, 3'b100);
            chk("rst_o", {x_o, busy_o, done_o}, 3'b100);
        end
        start = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        chk("post_rst", {x_e, busy_e, done_e}, 3'b100);

        // Basic frames
        send("a5_even", 8'hA5, 1'b0, 12'b001101001010, 12'h000, 1'b1);
        send("01_odd", 8'h01, 1'b1, 12'b001000000010, 12'h000, 1'b0);
        send("00_odd", 8'h00, 1'b1, 12'b001000000001, 12'h000, 1'b0);
        send("5a_even", 8'h5A, 1'b0, 12'b001010110100, 12'h000, 1'b0);

        // start pulses during MK2 and mid-DATA are ignored
        send("ign", 8'hA5, 1'b0, 12'b001101001010, 12'b001000100000, 1'b0);

        // start held high: back-to-back frames with a single gap
        din   = 8'hFF;
        start = 1'b1;
        tick();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) begin
                logic [11:0] e;
                e = 12'b001111111110;
                chk("hold_x", x_e, e[11-i]);
                chk("hold_bd", {busy_e, done_e}, 2'b10);
                tick();
            end
            chk("hold_gap", {x_e, busy_e, done_e}, 3'b101);
            tick();
        end
        chk("hold_mk0", {x_e, busy_e, done_e}, 3'b010);
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("hold_end", {x_e, busy_e, done_e}, 3'b100);

        // Async reset at payload bit 4 abandons the frame
        din   = 8'hA5;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("ar_bit4", {x_e, busy_e}, 2'b01);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_async", {x_e, busy_e, done_e}, 3'b100);
        tick();
        chk("ar_held", {x_e, busy_e, done_e}, 3'b100);
        reset = 1'b1;
        tick();
        chk("ar_rel", {x_e, busy_e, done_e}, 3'b100);
        tick();
        chk("ar_nodone", {x_e, busy_e, done_e}, 3'b100);
        send("ar_fresh", 8'hA5, 1'b0, 12'b001101001010, 12'h000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
